// File: rtl/lc2k_pkg.sv
// Shared LC2K pipeline types: opcodes, inter-stage bundles and MEM stage states.
package lc2k_pkg;

  localparam int LC2K_DATA_W = 32;
  localparam int LC2K_REG_W  = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_NOR  = 3'b001,
    OP_LW   = 3'b010,
    OP_SW   = 3'b011,
    OP_BEQ  = 3'b100,
    OP_JALR = 3'b101,
    OP_HALT = 3'b110,
    OP_NOOP = 3'b111
  } opcode_t;

  // Bundle produced by execute.
  typedef struct packed {
    logic [LC2K_DATA_W-1:0] alu_result;
    logic [LC2K_DATA_W-1:0] cont_reg_b;
    logic [LC2K_REG_W-1:0]  dest_reg;
    opcode_t                op_code;
    logic [LC2K_DATA_W-1:0] pc_target;
    logic                   branch_eq;
  } EX_MEM_REG;

  // Bundle consumed by writeback.
  typedef struct packed {
    logic [LC2K_DATA_W-1:0] write_data;
    logic [LC2K_REG_W-1:0]  dest_reg;
    opcode_t                op_code;
    logic                   reg_write;
  } MEM_WB_REG;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RD = 2'd1,
    WAIT_WR = 2'd2,
    HALT    = 2'd3
  } mem_state_t;

  // Only the ALU ops write the register file from the single-cycle path.
  function automatic logic alu_writes_reg(input opcode_t op);
    return (op == OP_ADD) || (op == OP_NOR);
  endfunction

endpackage

// File: rtl/dmem_timeout_counter.sv
// Counts cycles spent waiting on the data memory; flags the last allowed cycle.
module dmem_timeout_counter #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] count_reg;

  // Cleared on entry to a wait, advanced once per wait cycle.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Asserted on the wait cycle whose closing edge would bring the count to MEM_TIMEOUT.
  always_comb begin
    expired = enable && (count_reg == CNT_W'(MEM_TIMEOUT - 1));
  end

endmodule

// File: rtl/mem_stage.sv
// LC2K memory stage: lw/sw over a req/ack data memory, beq redirect, MEM/WB register.
module mem_stage
  import lc2k_pkg::*;
#(
  parameter int DATA_W      = LC2K_DATA_W,
  parameter int ADDR_W      = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  EX_MEM_REG         ex_mem_reg_in,
  input  logic              ex_mem_valid,
  output logic              ex_mem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output MEM_WB_REG         mem_wb_out,
  output logic              mem_wb_valid,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] branch_target,
  output logic              halted,
  output logic              mem_error
);

  mem_state_t        state_reg, state_next;
  EX_MEM_REG         held_reg, held_next;
  MEM_WB_REG         mem_wb_reg, mem_wb_next;
  logic              valid_reg, valid_next;
  logic              taken_reg, taken_next;
  logic [ADDR_W-1:0] target_reg, target_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              halted_reg, halted_next;
  logic              error_reg, error_next;
  logic              cnt_clear, cnt_enable, cnt_expired;
  logic              accept;

  // Address and target bits above ADDR_W are intentionally discarded.
  logic unused_bits;
  assign unused_bits = ^{ex_mem_reg_in.alu_result[DATA_W-1:ADDR_W],
                         ex_mem_reg_in.pc_target[DATA_W-1:ADDR_W],
                         held_reg.cont_reg_b, held_reg.pc_target, held_reg.branch_eq};

  dmem_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(cnt_expired)
  );

  // Ready only while idle and not halted.
  always_comb begin
    ex_mem_ready = (state_reg == IDLE) && !halted_reg;
    accept       = ex_mem_valid && ex_mem_ready;
  end

  // Next-state and next-output logic for the access FSM.
  always_comb begin
    state_next  = state_reg;
    held_next   = held_reg;
    mem_wb_next = mem_wb_reg;
    valid_next  = 1'b0;
    taken_next  = 1'b0;
    target_next = target_reg;
    req_next    = req_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    halted_next = halted_reg;
    error_next  = error_reg;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          held_next = ex_mem_reg_in;
          case (ex_mem_reg_in.op_code)
            OP_LW, OP_SW: begin
              state_next = (ex_mem_reg_in.op_code == OP_LW) ? WAIT_RD : WAIT_WR;
              req_next   = 1'b1;
              we_next    = (ex_mem_reg_in.op_code == OP_SW);
              addr_next  = ex_mem_reg_in.alu_result[ADDR_W-1:0];
              wdata_next = ex_mem_reg_in.cont_reg_b;
              cnt_clear  = 1'b1;
            end
            default: begin
              valid_next             = 1'b1;
              mem_wb_next.write_data = ex_mem_reg_in.alu_result;
              mem_wb_next.dest_reg   = ex_mem_reg_in.dest_reg;
              mem_wb_next.op_code    = ex_mem_reg_in.op_code;
              mem_wb_next.reg_write  = alu_writes_reg(ex_mem_reg_in.op_code);
              if (ex_mem_reg_in.op_code == OP_BEQ && ex_mem_reg_in.branch_eq) begin
                taken_next  = 1'b1;
                target_next = ex_mem_reg_in.pc_target[ADDR_W-1:0];
              end
              if (ex_mem_reg_in.op_code == OP_HALT) begin
                halted_next = 1'b1;
                state_next  = HALT;
              end
            end
          endcase
        end
      end

      WAIT_RD, WAIT_WR: begin
        cnt_enable = 1'b1;
        if (dmem_ack) begin
          req_next               = 1'b0;
          state_next             = IDLE;
          valid_next             = 1'b1;
          mem_wb_next.write_data = (state_reg == WAIT_RD) ? dmem_rdata : held_reg.alu_result;
          mem_wb_next.dest_reg   = held_reg.dest_reg;
          mem_wb_next.op_code    = held_reg.op_code;
          mem_wb_next.reg_write  = (state_reg == WAIT_RD);
        end else if (cnt_expired) begin
          req_next   = 1'b0;
          error_next = 1'b1;
          state_next = IDLE;
        end
      end

      HALT: begin
        state_next = HALT;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      held_reg   <= '0;
      mem_wb_reg <= '0;
      valid_reg  <= 1'b0;
      taken_reg  <= 1'b0;
      target_reg <= '0;
      req_reg    <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      halted_reg <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      held_reg   <= held_next;
      mem_wb_reg <= mem_wb_next;
      valid_reg  <= valid_next;
      taken_reg  <= taken_next;
      target_reg <= target_next;
      req_reg    <= req_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      halted_reg <= halted_next;
      error_reg  <= error_next;
    end
  end

  assign dmem_req      = req_reg;
  assign dmem_we       = we_reg;
  assign dmem_addr     = addr_reg;
  assign dmem_wdata    = wdata_reg;
  assign mem_wb_out    = mem_wb_reg;
  assign mem_wb_valid  = valid_reg;
  assign branch_taken  = taken_reg;
  assign branch_target = target_reg;
  assign halted        = halted_reg;
  assign mem_error     = error_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle ops plus memory/halt sequences.
module tb_mem_stage;
  import lc2k_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  EX_MEM_REG   in_reg;
  logic        ex_mem_valid;
  logic        ex_mem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  MEM_WB_REG   mem_wb_out;
  logic        mem_wb_valid;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halted;
  logic        mem_error;

  int tests = 0;
  int fails = 0;

  mem_stage #(
    .DATA_W(32),
    .ADDR_W(16),
    .MEM_TIMEOUT(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_mem_reg_in(in_reg),
    .ex_mem_valid (ex_mem_valid),
    .ex_mem_ready (ex_mem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .mem_wb_out   (mem_wb_out),
    .mem_wb_valid (mem_wb_valid),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halted       (halted),
    .mem_error    (mem_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    opcode_t     op;
    logic [31:0] alu;
    logic [2:0]  dest;
    logic [31:0] pc;
    logic        beq;
    logic [31:0] exp_wd;
    logic        exp_rw;
    logic        exp_taken;
    logic [15:0] exp_target;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input opcode_t op, input logic [31:0] alu, input logic [31:0] crb,
                       input logic [2:0] dest, input logic [31:0] pc, input logic beq);
    in_reg.op_code    = op;
    in_reg.alu_result = alu;
    in_reg.cont_reg_b = crb;
    in_reg.dest_reg   = dest;
    in_reg.pc_target  = pc;
    in_reg.branch_eq  = beq;
    ex_mem_valid      = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    in_reg       = '0;
    ex_mem_valid = 1'b0;
    dmem_ack     = 1'b0;
    dmem_rdata   = '0;

    vecs[0] = '{OP_ADD,  32'h0000_0005, 3'd3, 32'h0,    1'b0, 32'h0000_0005, 1'b1, 1'b0, 16'h0};
    vecs[1] = '{OP_NOR,  32'hFFFF_0000, 3'd7, 32'h0,    1'b0, 32'hFFFF_0000, 1'b1, 1'b0, 16'h0};
    vecs[2] = '{OP_BEQ,  32'h0000_0000, 3'd0, 32'h0040, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 16'h0040};
    vecs[3] = '{OP_BEQ,  32'h0000_0001, 3'd0, 32'h0080, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 16'h0};
    vecs[4] = '{OP_JALR, 32'h0000_1234, 3'd2, 32'h0,    1'b0, 32'h0000_1234, 1'b0, 1'b0, 16'h0};
    vecs[5] = '{OP_NOOP, 32'h0000_00AA, 3'd0, 32'h0,    1'b0, 32'h0000_00AA, 1'b0, 1'b0, 16'h0};
    vecs[6] = '{OP_ADD,  32'hFFFF_FFFF, 3'd1, 32'h0,    1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 16'h0};

    step();
    step();
    reset = 1'b0;
    step();
    $display("[TB] reset state");
    check("rst_valid", mem_wb_valid, 0);
    check("rst_req", dmem_req, 0);
    check("rst_halted", halted, 0);
    check("rst_error", mem_error, 0);
    check("rst_taken", branch_taken, 0);
    check("rst_ready", ex_mem_ready, 1);
    check("rst_mem_wb", mem_wb_out, 0);

    // Single-cycle ops from the table.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].op, vecs[i].alu, 32'h0, vecs[i].dest, vecs[i].pc, vecs[i].beq);
      step();
      ex_mem_valid = 1'b0;
      $display("[TB] vec %0d op=%0d alu=0x%0h wd=0x%0h rw=%0b taken=%0b",
               i, vecs[i].op, vecs[i].alu, mem_wb_out.write_data, mem_wb_out.reg_write, branch_taken);
      check("vec_valid", mem_wb_valid, 1);
      check("vec_wd", mem_wb_out.write_data, vecs[i].exp_wd);
      check("vec_dest", mem_wb_out.dest_reg, vecs[i].dest);
      check("vec_op", mem_wb_out.op_code, vecs[i].op);
      check("vec_rw", mem_wb_out.reg_write, vecs[i].exp_rw);
      check("vec_taken", branch_taken, vecs[i].exp_taken);
      if (vecs[i].exp_taken) check("vec_target", branch_target, vecs[i].exp_target);
      check("vec_req", dmem_req, 0);
      step();
      check("vec_valid_pulse", mem_wb_valid, 0);
      check("vec_taken_pulse", branch_taken, 0);
      check("vec_hold_wd", mem_wb_out.write_data, vecs[i].exp_wd);
    end

    // lw with ack three cycles after req rises.
    drive(OP_LW, 32'h0001_0010, 32'h0, 3'd4, 32'h0, 1'b0);
    step();
    ex_mem_valid = 1'b0;
    check("lw_req", dmem_req, 1);
    check("lw_we", dmem_we, 0);
    check("lw_addr", dmem_addr, 16'h0010);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
      end else if (c > 0) begin
        step();
      end
      check("lw_ready_low", ex_mem_ready, 0);
      check("lw_wait_valid", mem_wb_valid, 0);
      check("lw_req_hold", dmem_req, 1);
      if (c == 1) step();
    end
    step();
    dmem_ack = 1'b0;
    $display("[TB] lw addr=0x%0h wd=0x%0h", dmem_addr, mem_wb_out.write_data);
    check("lw_valid", mem_wb_valid, 1);
    check("lw_wd", mem_wb_out.write_data, 32'hDEAD_BEEF);
    check("lw_rw", mem_wb_out.reg_write, 1);
    check("lw_dest", mem_wb_out.dest_reg, 4);
    check("lw_req_drop", dmem_req, 0);
    check("lw_ready_back", ex_mem_ready, 1);

    // sw acked on the first wait cycle, add queued behind it.
    drive(OP_SW, 32'h0000_0020, 32'h0000_1234, 3'd0, 32'h0, 1'b0);
    step();
    check("sw_req", dmem_req, 1);
    check("sw_we", dmem_we, 1);
    check("sw_wdata", dmem_wdata, 32'h1234);
    check("sw_addr", dmem_addr, 16'h0020);
    dmem_ack = 1'b1;
    drive(OP_ADD, 32'h0000_0009, 32'h0, 3'd5, 32'h0, 1'b0);
    step();
    dmem_ack = 1'b0;
    $display("[TB] sw wdata=0x%0h rw=%0b", dmem_wdata, mem_wb_out.reg_write);
    check("sw_valid", mem_wb_valid, 1);
    check("sw_rw", mem_wb_out.reg_write, 0);
    check("sw_req_drop", dmem_req, 0);
    check("sw_ready", ex_mem_ready, 1);
    step();
    ex_mem_valid = 1'b0;
    $display("[TB] add behind sw wd=0x%0h", mem_wb_out.write_data);
    check("b2b_valid", mem_wb_valid, 1);
    check("b2b_wd", mem_wb_out.write_data, 32'h9);
    check("b2b_dest", mem_wb_out.dest_reg, 5);
    check("b2b_rw", mem_wb_out.reg_write, 1);

    // lw with ack withheld: four wait cycles then timeout.
    drive(OP_LW, 32'h0000_0044, 32'h0, 3'd6, 32'h0, 1'b0);
    step();
    ex_mem_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("to_req_hold", dmem_req, 1);
      check("to_no_valid", mem_wb_valid, 0);
      check("to_no_error", mem_error, 0);
      step();
    end
    $display("[TB] timeout req=%0b err=%0b", dmem_req, mem_error);
    check("to_req_drop", dmem_req, 0);
    check("to_error", mem_error, 1);
    check("to_valid", mem_wb_valid, 0);
    check("to_ready", ex_mem_ready, 1);
    drive(OP_ADD, 32'h0000_0007, 32'h0, 3'd6, 32'h0, 1'b0);
    step();
    ex_mem_valid = 1'b0;
    check("to_next_valid", mem_wb_valid, 1);
    check("to_next_wd", mem_wb_out.write_data, 32'h7);
    check("to_error_sticky", mem_error, 1);

    // Reset during WAIT_RD, then a stale ack.
    drive(OP_LW, 32'h0000_0008, 32'h0, 3'd2, 32'h0, 1'b0);
    step();
    ex_mem_valid = 1'b0;
    check("rr_req", dmem_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rr_req_drop", dmem_req, 0);
    check("rr_error_clr", mem_error, 0);
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    step();
    dmem_ack = 1'b0;
    $display("[TB] stale ack valid=%0b req=%0b", mem_wb_valid, dmem_req);
    check("rr_stale_valid", mem_wb_valid, 0);
    check("rr_stale_req", dmem_req, 0);
    check("rr_ready", ex_mem_ready, 1);

    // halt retires, then the stage refuses input until reset.
    drive(OP_HALT, 32'h0, 32'h0, 3'd0, 32'h0, 1'b0);
    step();
    $display("[TB] halt valid=%0b halted=%0b", mem_wb_valid, halted);
    check("halt_valid", mem_wb_valid, 1);
    check("halt_rw", mem_wb_out.reg_write, 0);
    check("halt_flag", halted, 1);
    check("halt_ready", ex_mem_ready, 0);
    drive(OP_ADD, 32'h0000_0003, 32'h0, 3'd1, 32'h0, 1'b0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("halt_blocked_valid", mem_wb_valid, 0);
      check("halt_blocked_ready", ex_mem_ready, 0);
      check("halt_sticky", halted, 1);
    end
    ex_mem_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("halt_rst_flag", halted, 0);
    check("halt_rst_ready", ex_mem_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
